sbox9_pipe: RTL and testbench

- Registered 9-bit bijective substitution box (S9): maps a 9-bit input symbol to a 9-bit output symbol, for use as the nonlinear layer of a 9-bit datapath cipher round.
- Mapping is the Gold power function x^5 over GF(2^9), followed by XOR with a constant.
- One register stage with a valid flag, so it drops straight into a pipelined round.

---
 rtl/sbox9_pkg.sv | 23 ++
 rtl/gf512_mul.sv | 29 ++
 rtl/sbox9_pipe.sv | 53 +++++
 tb/tb_sbox9_pipe.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sbox9_pkg.sv
// rtl/sbox9_pkg.sv - shared widths, field polynomial and squaring helper for the 9-bit S-box.
package sbox9_pkg;

  localparam int SYM_W = 9;
  // Low bits of P(x) = x^9 + x^4 + 1; the x^9 term is implicit.
  localparam logic [SYM_W-1:0] GF_POLY = 9'h011;
  localparam logic [SYM_W-1:0] S9_AFFINE_DEFAULT = 9'h0A7;

  function automatic logic [SYM_W-1:0] gf512_sq(input logic [SYM_W-1:0] x);
    logic [2*SYM_W-2:0] w;
    w = '0;
    for (int i = 0; i < SYM_W; i++) begin
      w[2*i] = x[i];
    end
    for (int i = 2*SYM_W-2; i >= SYM_W; i--) begin
      if (w[i]) begin
        w[i-SYM_W +: SYM_W] = w[i-SYM_W +: SYM_W] ^ GF_POLY;
      end
    end
    return w[SYM_W-1:0];
  endfunction

endpackage

// File: rtl/gf512_mul.sv
// rtl/gf512_mul.sv - combinational 9x9 GF(2^9) multiplier, carry-less product reduced mod P.
module gf512_mul
  import sbox9_pkg::*;
(
  input  logic [SYM_W-1:0] a_i,
  input  logic [SYM_W-1:0] b_i,
  output logic [SYM_W-1:0] p_o
);

  logic [2*SYM_W-2:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < SYM_W; i++) begin
      for (int j = 0; j < SYM_W; j++) begin
        prod[i+j] = prod[i+j] ^ (a_i[i] & b_i[j]);
      end
    end
    // Fold high terms down from the top so each fold sees earlier folds.
    for (int k = 2*SYM_W-2; k >= SYM_W; k--) begin
      if (prod[k]) begin
        prod[k-SYM_W +: SYM_W] = prod[k-SYM_W +: SYM_W] ^ GF_POLY;
      end
    end
  end

  assign p_o = prod[SYM_W-1:0];

endmodule

// File: rtl/sbox9_pipe.sv
// rtl/sbox9_pipe.sv - registered S9 S-box: z = a^5 XOR AFFINE_C over GF(2^9), one cycle latency.
module sbox9_pipe
  import sbox9_pkg::*;
#(
  parameter logic [SYM_W-1:0] AFFINE_C = S9_AFFINE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] a,
  output logic             out_valid,
  output logic [SYM_W-1:0] z
);

  // Squaring mod x^9 + x^4 + 1 as a fixed XOR network (x^10, x^12, x^14, x^16 folded in).
  function automatic logic [SYM_W-1:0] sq_net(input logic [SYM_W-1:0] x);
    return {x[4], x[6] ^ x[8], x[3] ^ x[8], x[5] ^ x[7], x[2] ^ x[7],
            x[6], x[1] ^ x[8], x[5], x[0] ^ x[7]};
  endfunction

  logic [SYM_W-1:0] a_pow2;
  logic [SYM_W-1:0] a_pow4;
  logic [SYM_W-1:0] a_pow5;
  logic [SYM_W-1:0] z_d, z_q;
  logic             valid_d, valid_q;

  assign a_pow2 = sq_net(a);
  assign a_pow4 = sq_net(a_pow2);

  gf512_mul u_mul (
    .a_i (a_pow4),
    .b_i (a),
    .p_o (a_pow5)
  );

  // The mux keeps a don't-care symbol on idle cycles away from the register.
  assign z_d     = in_valid ? (a_pow5 ^ AFFINE_C) : z_q;
  assign valid_d = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      z_q     <= '0;
    end else begin
      valid_q <= valid_d;
      z_q     <= z_d;
    end
  end

  assign out_valid = valid_q;
  assign z         = z_q;

endmodule

// File: tb/tb_sbox9_pipe.sv
// tb/tb_sbox9_pipe.sv - scoreboard bench for sbox9_pipe with default and zero affine constants.
module tb_sbox9_pipe;
  import sbox9_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [8:0] a;
  logic       ov1, ov0;
  logic [8:0] z1, z0;

  always #5 clk = ~clk;

  sbox9_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .out_valid(ov1), .z(z1)
  );

  sbox9_pipe #(.AFFINE_C(9'h000)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .out_valid(ov0), .z(z0)
  );

  int         checks = 0;
  int         failures = 0;
  logic [8:0] q1[$];
  logic [8:0] q0[$];
  logic       exp_v;
  logic [8:0] last1 = '0;
  logic [8:0] last0 = '0;
  bit         exh = 1'b0;
  int         exh_cnt = 0;
  bit         seen[512];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ref_mul(input logic [8:0] x, input logic [8:0] y);
    logic [8:0] r, t;
    r = '0;
    t = x;
    for (int i = 0; i < 9; i++) begin
      if (y[i]) r = r ^ t;
      t = t[8] ? ({t[7:0], 1'b0} ^ 9'h011) : {t[7:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [8:0] model(input logic [8:0] x, input logic [8:0] c);
    return ref_mul(gf512_sq(gf512_sq(x)), x) ^ c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_v <= 1'b0;
    else        exp_v <= in_valid;
  end

  always @(negedge rst_n) begin
    q1.delete();
    q0.delete();
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", {8'b0, ov1}, 9'h000);
      check("rst_z", z1, 9'h000);
      check("rst_valid0", {8'b0, ov0}, 9'h000);
      check("rst_z0", z0, 9'h000);
      last1 = '0;
      last0 = '0;
    end else begin
      check("valid", {8'b0, ov1}, {8'b0, exp_v});
      check("valid0", {8'b0, ov0}, {8'b0, exp_v});
      if (ov1) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL z_unexpected: got %h want none", z1);
        end else begin
          last1 = q1.pop_front();
          check("z", z1, last1);
        end
        if (exh) begin
          exh_cnt++;
          seen[z1] = 1'b1;
        end
      end else begin
        check("z_hold", z1, last1);
      end
      if (ov0) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL z0_unexpected: got %h want none", z0);
        end else begin
          last0 = q0.pop_front();
          check("z0", z0, last0);
        end
      end else begin
        check("z0_hold", z0, last0);
      end
    end
  end

  task automatic issue(input logic v, input logic [8:0] av, input logic [8:0] e1, input logic [8:0] e0);
    @(posedge clk);
    #1;
    in_valid = v;
    a        = av;
    if (v) begin
      q1.push_back(e1);
      q0.push_back(e0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int distinct;
    logic [8:0] gv;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed vectors: {a, z with 0x0A7, z with 0x000}.
    issue(1'b1, 9'h000, 9'h0A7, 9'h000);
    issue(1'b1, 9'h001, 9'h0A6, 9'h001);
    issue(1'b1, 9'h002, 9'h087, 9'h020);
    issue(1'b1, 9'h003, 9'h094, 9'h033);
    issue(1'b1, 9'h100, 9'h091, 9'h036);
    issue(1'b0, 9'h000, 9'h000, 9'h000);
    issue(1'b0, 9'h000, 9'h000, 9'h000);

    exh = 1'b1;
    for (int i = 0; i < 512; i++) begin
      issue(1'b1, 9'(i), model(9'(i), 9'h0A7), model(9'(i), 9'h000));
    end
    issue(1'b0, 9'h000, 9'h000, 9'h000);
    issue(1'b0, 9'h000, 9'h000, 9'h000);
    exh = 1'b0;
    distinct = 0;
    for (int i = 0; i < 512; i++) distinct += int'(seen[i]);
    check_int("exh_valid_cycles", exh_cnt, 512);
    check_int("exh_distinct", distinct, 512);

    for (int i = 0; i < 16; i++) begin
      gv = 9'(i * 37 + 5);
      issue((i % 2) == 0, gv, model(gv, 9'h0A7), model(gv, 9'h000));
    end
    issue(1'b0, 9'h000, 9'h000, 9'h000);
    issue(1'b0, 9'h000, 9'h000, 9'h000);

    issue(1'b1, 9'h0AB, model(9'h0AB, 9'h0A7), model(9'h0AB, 9'h000));
    issue(1'b1, 9'h1CD, model(9'h1CD, 9'h0A7), model(9'h1CD, 9'h000));
    @(posedge clk);
    #2 rst_n = 1'b0;
    a = 9'h155;
    #1;
    check("async_rst_valid", {8'b0, ov1}, 9'h000);
    check("async_rst_z", z1, 9'h000);
    check("async_rst_valid0", {8'b0, ov0}, 9'h000);
    check("async_rst_z0", z0, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    issue(1'b1, 9'h0F0, model(9'h0F0, 9'h0A7), model(9'h0F0, 9'h000));
    issue(1'b1, 9'h1FF, model(9'h1FF, 9'h0A7), model(9'h1FF, 9'h000));
    issue(1'b0, 9'h000, 9'h000, 9'h000);
    issue(1'b0, 9'h000, 9'h000, 9'h000);

    check_int("queue_drained", q1.size(), 0);
    check_int("queue0_drained", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
